// File: rtl/preescalador_pkg.sv
// Shared constants, helper function and per-channel state record for the tick-generator bank.
// Optional square-wave output is enabled with PREESCALADOR_TOGGLE_EN.
package preescalador_pkg;

  // State fields are sized for the widest supported counter; unused upper bits stay zero.
  localparam int N_MAX = 32;

  localparam logic [N_MAX-1:0] DIV_HALT = '0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [N_MAX-1:0] cnt;
    logic [N_MAX-1:0] act;
    logic [N_MAX-1:0] shd;
    logic             tick;
  } canal_st_t;

endpackage

// File: rtl/preescalador_canal.sv
// One tick-generator channel: counter, double-buffered divisor and registered tick.
// PREESCALADOR_TOGGLE_EN adds a registered square-wave output that flips on every tick.
module preescalador_canal
  import preescalador_pkg::*;
#(
  parameter int n   = 17,
  parameter int lim = 100000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ev_i,
  input  logic         sync_i,
  input  logic         wr_sel_i,
  input  logic [n-1:0] data_i,
  output logic         tick_o,
  output logic         pending_o
`ifdef PREESCALADOR_TOGGLE_EN
  , output logic       sq_o
`endif
);

  localparam canal_st_t ST_RST = '{
    cnt:  '0,
    act:  N_MAX'(lim),
    shd:  N_MAX'(lim),
    tick: 1'b0
  };

  canal_st_t st_q, st_d;

  always_comb begin
    st_d = st_q;
    if (wr_sel_i) st_d.shd = N_MAX'(data_i);
    // act always loads the pre-write shadow, so a same-cycle write waits one more period
    if (sync_i) begin
      st_d.cnt  = '0;
      st_d.tick = 1'b0;
    end else if (st_q.act == DIV_HALT) begin
      st_d.cnt  = '0;
      st_d.tick = 1'b0;
      if (st_q.shd != DIV_HALT) st_d.act = st_q.shd;
    end else if (ev_i && (st_q.cnt == st_q.act - N_MAX'(1))) begin
      st_d.cnt  = '0;
      st_d.tick = 1'b1;
      st_d.act  = st_q.shd;
    end else if (ev_i) begin
      st_d.cnt  = st_q.cnt + N_MAX'(1);
      st_d.tick = 1'b0;
    end else begin
      st_d.tick = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) st_q <= ST_RST;
    else       st_q <= st_d;
  end

  assign tick_o    = st_q.tick;
  assign pending_o = (st_q.shd != st_q.act);

`ifdef PREESCALADOR_TOGGLE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (sync_i)         sq_d = 1'b0;
    else if (st_d.tick) sq_d = ~sq_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sq_q <= 1'b0;
    else       sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/preescalador_multicanal.sv
// Bank of N_CH programmable tick generators with optional cascading from the channel below.
// PREESCALADOR_TOGGLE_EN adds the o_Sq square-wave outputs.
module preescalador_multicanal
  import preescalador_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int n    = 17,
  parameter int lim  = 100000,
  localparam int AW  = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_En,
  input  logic            i_Sync,
  input  logic            i_Wr,
  input  logic [AW-1:0]   i_Addr,
  input  logic [n-1:0]    i_Data,
  input  logic [N_CH-1:0] i_Casc,
  output logic [N_CH-1:0] o_Tick,
  output logic [N_CH-1:0] o_Pending
`ifdef PREESCALADOR_TOGGLE_EN
  , output logic [N_CH-1:0] o_Sq
`endif
);

  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] tick_prev;
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] wr_sel;

  // Channel 0 has no lower neighbour: feeding it a constant 1 makes its cascade bit a no-op.
  if (N_CH == 1) begin : g_prev_one
    assign tick_prev = 1'b1;
  end else begin : g_prev_many
    assign tick_prev = {tick[N_CH-2:0], 1'b1};
  end

  assign ev = {N_CH{i_En}} & (~i_Casc | tick_prev);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign wr_sel[k] = i_Wr && (i_Addr == AW'(k));

    preescalador_canal #(
      .n   (n),
      .lim (lim)
    ) u_canal (
      .clk_i     (i_Clk),
      .rst_i     (i_Reset),
      .ev_i      (ev[k]),
      .sync_i    (i_Sync),
      .wr_sel_i  (wr_sel[k]),
      .data_i    (i_Data),
      .tick_o    (tick[k]),
      .pending_o (o_Pending[k])
`ifdef PREESCALADOR_TOGGLE_EN
      , .sq_o    (o_Sq[k])
`endif
    );
  end

  assign o_Tick = tick;

endmodule

// File: tb/tb_preescalador_multicanal.sv
// Directed self-checking bench for preescalador_multicanal (N_CH=4, n=8, lim=5) plus a
// three-channel instance used to exercise out-of-range write addresses.
module tb_preescalador_multicanal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] data = '0;
  logic [3:0] casc = '0;
  logic [3:0] tick;
  logic [3:0] pend;

  logic       wr3 = 1'b0;
  logic [1:0] addr3 = '0;
  logic [7:0] data3 = '0;
  logic [2:0] tick3;
  logic [2:0] pend3;

`ifdef PREESCALADOR_TOGGLE_EN
  logic [3:0] sq;
  logic [2:0] sq3;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  preescalador_multicanal #(.N_CH(4), .n(8), .lim(5)) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_En      (en),
    .i_Sync    (sync),
    .i_Wr      (wr),
    .i_Addr    (addr),
    .i_Data    (data),
    .i_Casc    (casc),
    .o_Tick    (tick),
    .o_Pending (pend)
`ifdef PREESCALADOR_TOGGLE_EN
    , .o_Sq    (sq)
`endif
  );

  preescalador_multicanal #(.N_CH(3), .n(8), .lim(5)) dut3 (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_En      (en),
    .i_Sync    (sync),
    .i_Wr      (wr3),
    .i_Addr    (addr3),
    .i_Data    (data3),
    .i_Casc    (casc[2:0]),
    .o_Tick    (tick3),
    .o_Pending (pend3)
`ifdef PREESCALADOR_TOGGLE_EN
    , .o_Sq    (sq3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reset for one edge, check the reset state, then release with counting enabled.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sync = 1'b0; wr = 1'b0; wr3 = 1'b0; casc = '0;
    @(negedge clk);
    chk("reset tick",  32'(tick),  32'h0);
    chk("reset pend",  32'(pend),  32'h0);
    chk("reset tick3", 32'(tick3), 32'h0);
    chk("reset pend3", 32'(pend3), 32'h0);
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    // 1: free-running at lim=5; dut3 receives a write to address 3 (>= N_CH) that must be ignored.
    do_reset();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("t1 tick c=%0d", c),  32'(tick),  (c % 5 == 0) ? 32'hF : 32'h0);
      chk($sformatf("t1 tick3 c=%0d", c), 32'(tick3), (c % 5 == 0) ? 32'h7 : 32'h0);
      chk($sformatf("t1 pend3 c=%0d", c), 32'(pend3), 32'h0);
`ifdef PREESCALADOR_TOGGLE_EN
      chk($sformatf("t1 sq0 c=%0d", c),   32'(sq[0]), 32'((c / 5) % 2));
`else
      chk($sformatf("t1 pend c=%0d", c),  32'(pend),  32'h0);
`endif
      if (c == 1) begin wr3 = 1'b1; addr3 = 2'd3; data3 = 8'd2; end
      if (c == 2) wr3 = 1'b0;
    end

    // 2: write ch0=3 on edge 2; old period finishes, then period 3.
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("t2 tick0 c=%0d", c), 32'(tick[0]),
          (c == 5 || c == 8 || c == 11 || c == 14) ? 32'h1 : 32'h0);
      chk($sformatf("t2 tick31 c=%0d", c), 32'(tick[3:1]), (c % 5 == 0) ? 32'h7 : 32'h0);
      chk($sformatf("t2 pend c=%0d", c), 32'(pend), (c >= 2 && c <= 4) ? 32'h1 : 32'h0);
      if (c == 1) begin wr = 1'b1; addr = 2'd0; data = 8'd3; end
      if (c == 2) wr = 1'b0;
    end

    // 3: ch0=4, ch1=3 cascaded -> ch1 ticks once per 12 cycles, one after every third ch0 tick.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin wr = 1'b1; addr = 2'd0; data = 8'd4; end
      if (c == 2) begin addr = 2'd1; data = 8'd3; end
      if (c == 3) wr = 1'b0;
    end
    chk("t3 warmup tick", 32'(tick), 32'hF);
    sync = 1'b1; casc = 4'b0010;
    @(negedge clk);
    chk("t3 after sync tick", 32'(tick), 32'h0);
    sync = 1'b0;
    for (int d = 1; d <= 26; d++) begin
      @(negedge clk);
      chk($sformatf("t3 tick0 d=%0d", d), 32'(tick[0]), (d % 4 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t3 tick1 d=%0d", d), 32'(tick[1]), (d == 13 || d == 25) ? 32'h1 : 32'h0);
    end

    // 4: ch2=0 halts after the current period; writing 2 resumes with period 2.
    do_reset();
    wr = 1'b1; addr = 2'd2; data = 8'd0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("t4 tick2 c=%0d", c), 32'(tick[2]),
          (c == 5 || c == 11 || c == 13 || c == 15) ? 32'h1 : 32'h0);
      chk($sformatf("t4 pend2 c=%0d", c), 32'(pend[2]), (c <= 4 || c == 8) ? 32'h1 : 32'h0);
      if (c == 1) wr = 1'b0;
      if (c == 7) begin wr = 1'b1; addr = 2'd2; data = 8'd2; end
      if (c == 8) wr = 1'b0;
    end

    // 5: sync on a terminal-count edge suppresses the tick; next one D cycles later.
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("t5 tick c=%0d", c), 32'(tick), (c == 10) ? 32'hF : 32'h0);
`ifdef PREESCALADOR_TOGGLE_EN
      chk($sformatf("t5 sq c=%0d", c), 32'(sq), (c == 10 || c == 11) ? 32'hF : 32'h0);
`endif
      sync = (c == 4);
    end

    // 6: reset on the edge that would tick, with a write pending -> divisor back to lim.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin wr = 1'b1; addr = 2'd0; data = 8'd2; end
      if (c == 2) wr = 1'b0;
    end
    chk("t6 pend before reset", 32'(pend), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 tick in reset", 32'(tick), 32'h0);
    chk("t6 pend in reset", 32'(pend), 32'h0);
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("t6 tick c=%0d", c), 32'(tick), (c % 5 == 0) ? 32'hF : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
